// File: rtl/huffman_stage_ctrl.sv
// huffman_stage_ctrl: start/finish sequencer for the four Huffman stages.
// Optional stage watchdog is built when HUFF_STAGE_WDOG_EN is defined.
module huffman_stage_ctrl #(
  parameter int unsigned     TO_W     = 16,
  parameter logic [TO_W-1:0] TO_LIMIT = 16'd1000
) (
  input  logic       Clk_in,
  input  logic       n_Rst,
  input  logic       Start,
  input  logic       Abort,
  input  logic       Fin_getnum,
  input  logic       Fin_tree,
  input  logic       Fin_code,
  input  logic       Fin_out,
  output logic       Start_getnum,
  output logic       Start_tree,
  output logic       Start_code,
  output logic       Start_out,
  output logic       Busy,
  output logic       Done,
  output logic [2:0] Stage,
  output logic       Err,
  output logic [1:0] Err_stage
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GETNUM = 3'd1,
    S_TREE   = 3'd2,
    S_CODE   = 3'd3,
    S_OUT    = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  state_t r_state;
  state_t w_nxt;
  logic   r_start_q;
  logic   w_edge;
  logic   w_fin;
  logic   w_pulse;
  logic   w_adv;
  logic   w_to;
  logic   w_in_stage;

  assign w_edge     = Start & ~r_start_q;
  assign w_in_stage = (r_state == S_GETNUM) || (r_state == S_TREE) ||
                      (r_state == S_CODE)   || (r_state == S_OUT);

  // Fin is ignored while its own start pulse is still on the wire
  always_comb begin
    w_fin   = 1'b0;
    w_pulse = 1'b0;
    unique case (r_state)
      S_GETNUM: begin w_fin = Fin_getnum; w_pulse = Start_getnum; end
      S_TREE:   begin w_fin = Fin_tree;   w_pulse = Start_tree;   end
      S_CODE:   begin w_fin = Fin_code;   w_pulse = Start_code;   end
      S_OUT:    begin w_fin = Fin_out;    w_pulse = Start_out;    end
      default:  ;
    endcase
  end

  assign w_adv = w_fin & ~w_pulse;

`ifdef HUFF_STAGE_WDOG_EN
  logic [TO_W-1:0] r_cnt;
  logic [1:0]      w_idx;

  assign w_to  = w_in_stage && (r_cnt == TO_LIMIT);
  assign w_idx = 2'(r_state - 3'd1);

  always_ff @(posedge Clk_in or negedge n_Rst) begin
    if (!n_Rst) begin
      r_cnt <= '0;
    end else if (!w_in_stage || (w_nxt != r_state)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + {{(TO_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge Clk_in or negedge n_Rst) begin
    if (!n_Rst) begin
      Err       <= 1'b0;
      Err_stage <= 2'd0;
    end else if (w_nxt != S_ERR) begin
      Err       <= 1'b0;
      Err_stage <= 2'd0;
    end else if (r_state != S_ERR) begin
      Err       <= 1'b1;
      Err_stage <= w_idx;
    end
  end
`else
  logic [TO_W-1:0] w_unused_lim;

  assign w_unused_lim = TO_LIMIT;
  assign w_to         = 1'b0;
  assign Err          = 1'b0;
  assign Err_stage    = 2'd0;
`endif

  // Abort outranks both Fin and the watchdog
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_edge && !Abort) w_nxt = S_GETNUM;
      end
      S_GETNUM, S_TREE, S_CODE, S_OUT: begin
        if (Abort)      w_nxt = S_IDLE;
        else if (w_adv) w_nxt = state_t'(r_state + 3'd1);
        else if (w_to)  w_nxt = S_ERR;
      end
      S_DONE: w_nxt = S_IDLE;
      S_ERR: begin
        if (Abort)       w_nxt = S_IDLE;
        else if (w_edge) w_nxt = S_GETNUM;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk_in or negedge n_Rst) begin
    if (!n_Rst) begin
      r_state      <= S_IDLE;
      r_start_q    <= 1'b0;
      Stage        <= 3'd0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      Start_getnum <= 1'b0;
      Start_tree   <= 1'b0;
      Start_code   <= 1'b0;
      Start_out    <= 1'b0;
    end else begin
      r_state      <= w_nxt;
      r_start_q    <= Start;
      Stage        <= w_nxt;
      Busy         <= (w_nxt >= S_GETNUM) && (w_nxt <= S_OUT);
      Done         <= (w_nxt == S_DONE);
      Start_getnum <= (w_nxt == S_GETNUM) && (r_state != S_GETNUM);
      Start_tree   <= (w_nxt == S_TREE)   && (r_state != S_TREE);
      Start_code   <= (w_nxt == S_CODE)   && (r_state != S_CODE);
      Start_out    <= (w_nxt == S_OUT)    && (r_state != S_OUT);
    end
  end

endmodule
